// File: rtl/sudoku_pkg.sv
// ---------------------------------------------------------------------------
// sudoku_pkg
//   Shared constants and types for the backtracking Sudoku solver blocks.
//   Grid layout: cell i occupies bits [9i+8:9i]; bit k set = digit k+1 legal.
//   Contents:
//     GRID_W, CELL_W, NCELLS, IDX_W, POSS_W  - grid geometry
//     POSS_SOLVED                            - minPoss code for "no open cell"
//     MAX_GUESS                              - most guesses one cell can take
//     guessState_t                           - guess_iter FSM states
//     satIncCnt()                            - saturating guess counter step
// ---------------------------------------------------------------------------
package sudoku_pkg;

   localparam int CELL_W = 9;
   localparam int NCELLS = 81;
   localparam int GRID_W = CELL_W * NCELLS;
   localparam int IDX_W  = 7;
   localparam int POSS_W = 4;

   localparam logic [POSS_W-1:0] POSS_SOLVED = 4'hF;
   localparam logic [3:0]        MAX_GUESS   = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PRESENT,
      ST_WAIT,
      ST_DONE
   } guessState_t;

   // A cell never has more than nine candidates, so the count stops at nine.
   function automatic logic [3:0] satIncCnt(input logic [3:0] cnt);
      return (cnt >= MAX_GUESS) ? cnt : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/guess_iter_lowest_bit9.sv
// ---------------------------------------------------------------------------
// lowest_bit9
//   Combinational lowest-set-bit finder for a 9-bit candidate mask.
//   Ports:
//     mask   in  9  candidate mask, bit k = digit k+1
//     oneHot out 9  mask with only its lowest set bit kept (0 if mask==0)
//     digit  out 4  position of that bit plus one, 1..9 (0 if mask==0)
//     none   out 1  mask has no bit set
// ---------------------------------------------------------------------------
module lowest_bit9
   import sudoku_pkg::*;
(
   input  logic [CELL_W-1:0] mask,
   output logic [CELL_W-1:0] oneHot,
   output logic [3:0]        digit,
   output logic              none
);

   // Scan from the top down so the last hit, i.e. the lowest bit, wins.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      oneHot = '0;
      digit  = '0;
      for (int k = CELL_W - 1; k >= 0; k--) begin
         if (mask[k]) begin
            oneHot    = '0;
            oneHot[k] = 1'b1;
            digit     = 4'(k + 1);
         end
      end
      none = (mask == '0);
   end

endmodule

// File: rtl/guess_iter.sv
// ---------------------------------------------------------------------------
// guess_iter
//   Branch-guess generator for the backtracking solver. Captures a grid and
//   the cell with the fewest candidates, then presents copies of the grid
//   with that cell forced to one candidate, lowest digit first, advancing on
//   each retry until the solver commits or the candidates run out.
//   Ports:
//     clk        in   1    clock
//     rst        in   1    asynchronous active-low reset
//     start      in   1    capture inGrid/minIdx/minPoss (IDLE only)
//     inGrid     in   729  flattened grid
//     minIdx     in   7    selected cell, 0..80
//     minPoss    in   4    candidate count; 4'hF solved, 0 contradiction
//     out_valid  out  1    guess grid valid (PRESENT)
//     out_ready  in   1    solver takes the guess
//     outGrid    out  729  captured grid with cell guessIdx one-hot
//     guessIdx   out  7    cell being guessed
//     guessVal   out  4    guessed digit 1..9
//     guessCnt   out  4    guesses issued for this cell
//     retry      in   1    last guess failed, try the next candidate
//     commit     in   1    last guess held, release the block
//     solved     out  1    pulse: grid had no unresolved cell
//     exhausted  out  1    pulse: contradiction or candidates used up
//     busy       out  1    not IDLE
// ---------------------------------------------------------------------------
module guess_iter #(
   parameter int NCELLS = sudoku_pkg::NCELLS,
   parameter int CELL_W = sudoku_pkg::CELL_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [NCELLS*CELL_W-1:0]         inGrid,
   input  logic [sudoku_pkg::IDX_W-1:0]     minIdx,
   input  logic [sudoku_pkg::POSS_W-1:0]    minPoss,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NCELLS*CELL_W-1:0]         outGrid,
   output logic [sudoku_pkg::IDX_W-1:0]     guessIdx,
   output logic [3:0]                       guessVal,
   output logic [3:0]                       guessCnt,
   input  logic                             retry,
   input  logic                             commit,
   output logic                             solved,
   output logic                             exhausted,
   output logic                             busy
);

   import sudoku_pkg::*;

   localparam int GW = NCELLS * CELL_W;

   guessState_t       state;
   guessState_t       stateNext;

   logic [GW-1:0]     gridQ;      // grid as captured at start
   logic [CELL_W-1:0] remMask;    // candidates not yet handed out
   logic              doneSolved; // which pulse DONE drives

   logic [CELL_W-1:0] startMask;
   logic              startSolved;
   logic              startBad;

   logic [CELL_W-1:0] lowHot;
   logic [3:0]        lowDigit;
   logic              lowNone;
   logic [GW-1:0]     loadGrid;

   // Mask of the selected cell straight from the incoming grid. An index
   // past the last cell matches nothing and reads as an empty mask.
   always_comb begin
      startMask = '0;
      for (int i = 0; i < NCELLS; i++) begin
         if (minIdx == IDX_W'(i)) begin
            startMask = inGrid[i*CELL_W +: CELL_W];
         end
      end
   end

   // Solved takes priority: 4'hF means there is no cell to inspect at all.
   assign startSolved = (minPoss == POSS_SOLVED);
   assign startBad    = (minPoss == '0) || (minIdx >= IDX_W'(NCELLS)) ||
                        (startMask == '0);

   lowest_bit9 uLowest (
      .mask   (remMask),
      .oneHot (lowHot),
      .digit  (lowDigit),
      .none   (lowNone)
   );

   // Guess grid: every cell passes through except the guessed one, which
   // is replaced by the lowest remaining candidate as a one-hot value.
   for (genvar g = 0; g < NCELLS; g++) begin : gCell
      assign loadGrid[g*CELL_W +: CELL_W] =
         (guessIdx == IDX_W'(g)) ? lowHot : gridQ[g*CELL_W +: CELL_W];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state and state-decoded outputs.
   always_comb begin
      stateNext = state;
      out_valid = 1'b0;
      busy      = 1'b1;
      solved    = 1'b0;
      exhausted = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               stateNext = (startSolved || startBad) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            stateNext = ST_PRESENT;
         end
         ST_PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Commit is checked first so it wins over a simultaneous retry.
            if (commit) begin
               stateNext = ST_IDLE;
            end else if (retry) begin
               stateNext = lowNone ? ST_DONE : ST_LOAD;
            end
         end
         ST_DONE: begin
            solved    = doneSolved;
            exhausted = !doneSolved;
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the wide grid registers are reset too, so outGrid reads 0
         // after reset rather than stale contents from an aborted search.
         gridQ      <= '0;
         outGrid    <= '0;
         remMask    <= '0;
         guessIdx   <= '0;
         guessVal   <= '0;
         guessCnt   <= '0;
         doneSolved <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every register here samples
         // the pre-edge values no matter the statement order.
         case (state)
            ST_IDLE: begin
               if (start) begin
                  gridQ      <= inGrid;
                  guessIdx   <= minIdx;
                  remMask    <= startMask;
                  guessCnt   <= '0;
                  doneSolved <= startSolved;
               end
            end
            ST_LOAD: begin
               guessVal <= lowDigit;
               outGrid  <= loadGrid;
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  // remMask is unchanged since LOAD, so lowHot is still the
                  // candidate currently on display.
                  remMask  <= remMask & ~lowHot;
                  guessCnt <= satIncCnt(guessCnt);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_guess_iter.sv
// ---------------------------------------------------------------------------
// tb_guess_iter
//   Self-checking bench for guess_iter. A driver issues searches and pushes
//   the expected guesses/pulses into a scoreboard queue; a monitor pops and
//   compares whenever a new guess appears or a pulse fires.
// ---------------------------------------------------------------------------
module tb_guess_iter;
   import sudoku_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [GRID_W-1:0] inGrid = '0;
   logic [IDX_W-1:0]  minIdx = '0;
   logic [POSS_W-1:0] minPoss = '0;
   logic              out_ready = 1'b0;
   logic              retry = 1'b0;
   logic              commit = 1'b0;
   logic              out_valid;
   logic [GRID_W-1:0] outGrid;
   logic [IDX_W-1:0]  guessIdx;
   logic [3:0]        guessVal;
   logic [3:0]        guessCnt;
   logic              solved;
   logic              exhausted;
   logic              busy;

   guess_iter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inGrid    (inGrid),
      .minIdx    (minIdx),
      .minPoss   (minPoss),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outGrid   (outGrid),
      .guessIdx  (guessIdx),
      .guessVal  (guessVal),
      .guessCnt  (guessCnt),
      .retry     (retry),
      .commit    (commit),
      .solved    (solved),
      .exhausted (exhausted),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef enum logic [1:0] {EV_GUESS, EV_SOLVED, EV_EXH} evKind_t;
   typedef struct {
      evKind_t           kind;
      logic [GRID_W-1:0] grid;
      int                idx;
      int                val;
      int                cnt;
   } ev_t;

   ev_t expQ[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkGrid(input string name, input logic [GRID_W-1:0] act,
                            input logic [GRID_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [8:0] cellOf(input logic [GRID_W-1:0] g, input int i);
      return g[i*9 +: 9];
   endfunction

   // n-th (1-based) legal digit of a mask, counting upward from 1.
   function automatic int nthDigit(input logic [8:0] m, input int n);
      int seen = 0;
      for (int d = 1; d <= 9; d++) begin
         if (m[d-1]) begin
            seen++;
            if (seen == n) return d;
         end
      end
      return 0;
   endfunction

   function automatic logic [GRID_W-1:0] withGuess(input logic [GRID_W-1:0] g,
                                                   input int idx, input int d);
      logic [GRID_W-1:0] r = g;
      logic [8:0] v = '0;
      v[d-1] = 1'b1;
      r[idx*9 +: 9] = v;
      return r;
   endfunction

   function automatic logic [GRID_W-1:0] randGrid();
      logic [GRID_W-1:0] r;
      for (int i = 0; i < 81; i++) r[i*9 +: 9] = 9'($urandom_range(0, 511));
      return r;
   endfunction

   task automatic pushGuess(input logic [GRID_W-1:0] g, input int idx,
                            input logic [8:0] m, input int k);
      ev_t e;
      e.kind = EV_GUESS;
      e.idx  = idx;
      e.val  = nthDigit(m, k);
      e.cnt  = k - 1;
      e.grid = withGuess(g, idx, e.val);
      expQ.push_back(e);
   endtask

   task automatic pushPulse(input evKind_t k);
      ev_t e;
      e.kind = k;
      e.grid = '0;
      e.idx  = 0;
      e.val  = 0;
      e.cnt  = 0;
      expQ.push_back(e);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      ev_t  e;
      logic prevValid;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !prevValid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected guess: val %0d idx %0d, expected none", guessVal, guessIdx);
            end else begin
               e = expQ.pop_front();
               check("event kind at guess", 32'(EV_GUESS), 32'(e.kind));
               if (e.kind == EV_GUESS) begin
                  check("guessVal", 32'(guessVal), e.val);
                  check("guessIdx", 32'(guessIdx), e.idx);
                  check("guessCnt at present", 32'(guessCnt), e.cnt);
                  checkGrid("outGrid", outGrid, e.grid);
               end
            end
         end
         if (solved || exhausted) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected pulse: solved %0b exhausted %0b, expected none", solved, exhausted);
            end else begin
               e = expQ.pop_front();
               check("pulse solved", 32'(solved), 32'(e.kind == EV_SOLVED));
               check("pulse exhausted", 32'(exhausted), 32'(e.kind == EV_EXH));
            end
         end
         prevValid = out_valid;
      end
   end

   // ---------------- driver ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // commitAfter: commit after that many accepted guesses (0 = retry to the end)
   task automatic runSearch(input logic [GRID_W-1:0] g, input int idx, input logic [3:0] poss,
                            input int commitAfter, input int hold, input bit both,
                            input bit startBusy);
      logic [8:0] m;
      int  n;
      bit  isSolved, isBad;
      m = (idx < 81) ? cellOf(g, idx) : 9'h0;
      n = $countones(m);
      isSolved = (poss == 4'hF);
      isBad    = !isSolved && (poss == 4'h0 || idx > 80 || m == 9'h0);
      if (isSolved) pushPulse(EV_SOLVED);
      else if (isBad) pushPulse(EV_EXH);
      else pushGuess(g, idx, m, 1);
      inGrid  = g;
      minIdx  = 7'(idx);
      minPoss = poss;
      start   = 1'b1;
      cyc();
      start = 1'b0;
      if (isSolved || isBad) begin
         check("solved one cycle after start", 32'(solved), 32'(isSolved));
         check("exhausted one cycle after start", 32'(exhausted), 32'(isBad));
         check("no guess on early finish", 32'(out_valid), 0);
         cyc();
         check("idle after pulse", 32'(busy), 0);
         return;
      end
      check("out_valid low in load", 32'(out_valid), 0);
      check("busy after start", 32'(busy), 1);
      for (int k = 1; k <= n; k++) begin
         cyc();
         check("out_valid two cycles after start/retry", 32'(out_valid), 1);
         for (int h = 0; h < hold; h++) begin
            if (startBusy && h == 0) begin
               start   = 1'b1;
               inGrid  = ~g;
               minIdx  = 7'((idx + 1) % 81);
               minPoss = 4'hF;
            end
            retry  = 1'b1;
            commit = 1'b1;
            cyc();
            start  = 1'b0;
            retry  = 1'b0;
            commit = 1'b0;
            check("out_valid held", 32'(out_valid), 1);
            check("guessIdx held", 32'(guessIdx), idx);
            check("guessVal held", 32'(guessVal), nthDigit(m, k));
            checkGrid("outGrid held", outGrid, withGuess(g, idx, nthDigit(m, k)));
         end
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         check("out_valid drops after accept", 32'(out_valid), 0);
         check("guessCnt after accept", 32'(guessCnt), k);
         // idle WAIT cycles; a stray out_ready here must do nothing
         for (int w = $urandom_range(0, 2); w > 0; w--) begin
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
         end
         check("busy in wait", 32'(busy), 1);
         if (k == commitAfter) begin
            commit = 1'b1;
            retry  = both;
            cyc();
            commit = 1'b0;
            retry  = 1'b0;
            check("idle after commit", 32'(busy), 0);
            cyc();
            check("no guess after commit", 32'(out_valid), 0);
            return;
         end
         if (k < n) pushGuess(g, idx, m, k + 1);
         else pushPulse(EV_EXH);
         retry = 1'b1;
         cyc();
         retry = 1'b0;
         if (k == n) begin
            check("exhausted after last retry", 32'(exhausted), 1);
            check("guessCnt at exhaustion", 32'(guessCnt), n);
            cyc();
            check("idle after exhaustion", 32'(busy), 0);
            return;
         end
         check("out_valid low after retry", 32'(out_valid), 0);
      end
   endtask

   initial begin : driver
      logic [GRID_W-1:0] g;
      logic [8:0] m;
      int  idx, n, sel;
      logic [3:0] poss;

      // reset state
      repeat (3) cyc();
      check("reset out_valid", 32'(out_valid), 0);
      check("reset busy", 32'(busy), 0);
      check("reset solved", 32'(solved), 0);
      check("reset exhausted", 32'(exhausted), 0);
      check("reset guessVal", 32'(guessVal), 0);
      check("reset guessIdx", 32'(guessIdx), 0);
      check("reset guessCnt", 32'(guessCnt), 0);
      checkGrid("reset outGrid", outGrid, '0);
      rst = 1'b1;
      cyc();

      // two candidates on cell 10: digits 2 then 5, then exhaustion
      g = randGrid();
      g[10*9 +: 9] = 9'b000010010;
      runSearch(g, 10, 4'd2, 0, 0, 1'b0, 1'b0);

      // full mask on the last cell: digits 1..9, then exhaustion
      g = randGrid();
      g[80*9 +: 9] = 9'h1FF;
      runSearch(g, 80, 4'd9, 0, 0, 1'b0, 1'b0);

      // classification at start
      runSearch(randGrid(), 5, 4'hF, 0, 0, 1'b0, 1'b0);
      g = randGrid();
      g[7*9 +: 9] = 9'h011;
      runSearch(g, 7, 4'h0, 0, 0, 1'b0, 1'b0);
      runSearch(randGrid(), 81, 4'd3, 0, 0, 1'b0, 1'b0);
      g = randGrid();
      g[40*9 +: 9] = 9'h000;
      runSearch(g, 40, 4'd3, 0, 0, 1'b0, 1'b0);

      // back-pressure, start while busy, commit+retry together
      g = randGrid();
      g[33*9 +: 9] = 9'b101001000;
      runSearch(g, 33, 4'd3, 1, 5, 1'b1, 1'b1);

      // reset while a guess is presented
      g = randGrid();
      g[30*9 +: 9] = 9'h0A4;
      pushGuess(g, 30, 9'h0A4, 1);
      inGrid  = g;
      minIdx  = 7'd30;
      minPoss = 4'd3;
      start   = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      check("present before reset", 32'(out_valid), 1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("out_valid cleared by reset", 32'(out_valid), 0);
      check("busy cleared by reset", 32'(busy), 0);
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      check("idle after reset release", 32'(busy), 0);

      // random searches
      for (int t = 0; t < 40; t++) begin
         g   = randGrid();
         idx = $urandom_range(0, 80);
         m   = 9'($urandom_range(1, 511));
         g[idx*9 +: 9] = m;
         n   = $countones(m);
         sel = $urandom_range(0, 15);
         if (sel == 0) poss = 4'hF;
         else if (sel == 1) poss = 4'h0;
         else poss = 4'(n);
         runSearch(g, idx, poss, $urandom_range(0, n), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (4) cyc();
      check("scoreboard drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
